// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: states, opcodes,
// ALU codes, immediate formats and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECUTER = 4'd7,
        EXECUTEI = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10,
        JAL      = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Must match the immediate extender's format select.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: maps alu_op plus instruction fields to alu_control.
// Shared with the single-cycle core variants.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7_5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // op5 separates R-type sub from addi, whose imm[10] aliases funct7_5
                    3'b000:  alu_control_o = (op5_i & funct7_5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM main controller for the multicycle core; every output is decoded
// from the state register and the current instruction fields.
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal_instr
);

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;
    logic       take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RD2;
        alu_op        = ALUOP_ADD;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        branch        = 1'b0;
        pc_update     = 1'b0;
        case (state_q)
            S_RESET: state_d = FETCH;
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_update  = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BR:        state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = FETCH;
            end
            EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  take = zero;
            3'b001:  take = ~zero;
            default: take = 1'b0;
        endcase
    end

    assign pc_write = pc_update | (branch & take);
    assign imm_src  = imm_src_of(op);

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7_5_i    (funct7_5),
        .alu_control_o (alu_control)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes the expected
// output vector, a negedge monitor pops and compares it.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_q[$];
    string       tag_q[$];
    logic [16:0] obs;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .reg_write(reg_write), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, alu_control, imm_src, reg_write, illegal_instr};

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b (pcw adr mw irw res sa sb alu imm rw ill)",
                     tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end

    function automatic logic [16:0] mk(
        input logic pcw, input logic adr, input logic mw, input logic irw,
        input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
        input logic [2:0] alu, input logic [1:0] imm, input logic rw, input logic ill);
        return {pcw, adr, mw, irw, res, sa, sb, alu, imm, rw, ill};
    endfunction

    // Expected outputs per state, written straight from the control table.
    function automatic logic [16:0] e_idle(input logic [1:0] imm);
        return mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,imm,0,0);
    endfunction
    function automatic logic [16:0] e_fetch(input logic [1:0] imm);
        return mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,imm,0,0);
    endfunction
    function automatic logic [16:0] e_decode(input logic [1:0] imm, input logic ill);
        return mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,imm,0,ill);
    endfunction

    task automatic step(input string tag, input logic [16:0] want);
        exp_q.push_back(want);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7_5 = f7;
    endtask

    task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] alu);
        set_instr(o, f3, f7);
        step({tag, "_fetch"}, e_fetch(2'b00));
        step({tag, "_decode"}, e_decode(2'b00, 0));
        if (o == 7'b0110011) step({tag, "_exr"}, mk(0,0,0,0,2'b00,2'b10,2'b00,alu,2'b00,0,0));
        else                 step({tag, "_exi"}, mk(0,0,0,0,2'b00,2'b10,2'b01,alu,2'b00,0,0));
        step({tag, "_aluwb"}, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));
    endtask

    task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                              input logic pcw);
        set_instr(7'b1100011, f3, 0);
        zero = ~z;
        step({tag, "_fetch"}, e_fetch(2'b10));
        step({tag, "_decode"}, e_decode(2'b10, 0));
        zero = z;
        step({tag, "_branch"}, mk(pcw,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0));
    endtask

    initial begin
        reset = 1'b1;
        set_instr(7'b0000000, 3'b000, 0);
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("in_reset", obs, e_idle(2'b00));
        reset = 1'b0;
        step("s_reset", e_idle(2'b00));

        // lw: 5 cycles
        set_instr(7'b0000011, 3'b010, 0);
        step("lw_fetch", e_fetch(2'b00));
        step("lw_decode", e_decode(2'b00, 0));
        step("lw_memadr", mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
        step("lw_memread", mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0));
        step("lw_memwb", mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1,0));

        run_alu("sub",  7'b0110011, 3'b000, 1, 3'b001);
        run_alu("addi", 7'b0010011, 3'b000, 1, 3'b000);
        run_alu("add",  7'b0110011, 3'b000, 0, 3'b000);
        run_alu("slt",  7'b0110011, 3'b010, 0, 3'b101);
        run_alu("ori",  7'b0010011, 3'b110, 0, 3'b011);
        run_alu("and",  7'b0110011, 3'b111, 1, 3'b010);
        run_alu("sll",  7'b0110011, 3'b001, 0, 3'b000);

        run_branch("bne_nz", 3'b001, 0, 1);
        run_branch("bne_z",  3'b001, 1, 0);
        run_branch("beq_z",  3'b000, 1, 1);
        run_branch("beq_nz", 3'b000, 0, 0);
        run_branch("blt_z",  3'b100, 1, 0);

        // jal: 4 cycles
        set_instr(7'b1101111, 3'b000, 0);
        step("jal_fetch", e_fetch(2'b11));
        step("jal_decode", e_decode(2'b11, 0));
        step("jal_jal", mk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,0));
        step("jal_aluwb", mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b11,1,0));

        // sw: 4 cycles
        set_instr(7'b0100011, 3'b010, 0);
        step("sw_fetch", e_fetch(2'b01));
        step("sw_decode", e_decode(2'b01, 0));
        step("sw_memadr", mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0));
        step("sw_memwrite", mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));

        // illegal: 2 cycles, flag for DECODE only
        set_instr(7'b1111111, 3'b000, 0);
        step("ill_fetch", e_fetch(2'b00));
        step("ill_decode", e_decode(2'b00, 1));
        set_instr(7'b0110011, 3'b000, 0);
        step("after_ill_fetch", e_fetch(2'b00));
        step("after_ill_decode", e_decode(2'b00, 0));
        step("after_ill_exr", mk(0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b00,0,0));
        step("after_ill_aluwb", mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));

        // reset asserted in the middle of MEMWRITE
        set_instr(7'b0100011, 3'b010, 0);
        step("sw2_fetch", e_fetch(2'b01));
        step("sw2_decode", e_decode(2'b01, 0));
        step("sw2_memadr", mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0));
        #1;
        chk("sw2_memwrite_pre", obs, mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));
        reset = 1'b1;
        #1;
        chk("async_reset_drop", obs, e_idle(2'b01));
        @(posedge clk);
        #1;
        chk("reset_held", obs, e_idle(2'b01));
        reset = 1'b0;
        step("s_reset2", e_idle(2'b01));
        step("post_reset_fetch", e_fetch(2'b01));

        @(negedge clk);
        chk("scoreboard_drained", {15'd0, exp_q.size() != 0}, 17'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main controller for the multicycle RV32I-subset core.
- Moore FSM sequences fetch/decode/execute/memory/writeback and drives every datapath mux select and write strobe.
- Sits upstream of the immediate extender: produces imm_src, decoded from the instruction-register opcode.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq/bne, jal.

Parameters:
- None. All encodings are fixed constants in the shared package.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag, current cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0=PC, 1=Result
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction/OldPC register enable
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  00=PC, 01=OldPC, 10=RD1
- alu_src_b  out  2  00=RD2, 01=ImmExt, 10=constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00 I, 01 S, 10 B, 11 J (extender encoding)
- reg_write  out  1  register file write enable
- illegal_instr  out  1  unsupported opcode seen in DECODE

Behaviour:
- State register: reset asynchronous, active-high, forces S_RESET. All other state changes occur on the rising edge of clk.
- S_RESET: all outputs 0 except imm_src (decoded from op). Next state is always FETCH. This gives one cycle of no strobes after reset is released.
- Defaults in every state: all strobes 0, all selects 00, alu_op=00.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, result_src=10, pc_update=1. Next: DECODE.
- DECODE: alu_src_a=01, alu_src_b=01 (branch target precompute). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> FETCH, with illegal_instr=1 for this cycle only
- MEMADR: alu_src_a=10, alu_src_b=01. Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Next: FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next: ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Next: FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1. Next: ALUWB.
- pc_write = pc_update | (branch & take).
  - take = zero when funct3=000; ~zero when funct3=001; 0 for any other funct3.
  - pc_write is combinational on zero within the BRANCH cycle.
- imm_src is combinational from op:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - all others -> 00
- ALU decoder (combinational):
  - alu_op 00 -> add; alu_op 01 -> sub.
  - alu_op 10, funct3 000 -> sub if (op[5] & funct7_5), else add (so addi never subtracts).
  - alu_op 10, funct3 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
- Cycle counts, FETCH to next FETCH: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4, illegal 2.
- Reset mid-instruction: returns immediately to S_RESET and all strobes drop in the same cycle. No partial write completes after reset assertion.
- Outputs are glitch-relevant only at clock edges. No registered outputs; all are decoded from state plus inputs.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum encoding (S_RESET, FETCH … JAL, 4 bits)
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL)
  - alu_control codes
  - imm_src codes, identical to the extender's
  - mux-select constants
- Sub-module alu_decoder (alu_op, funct3, op5, funct7_5 -> alu_control). It is combinational and reused by single-cycle variants.

Test Plan:
- Reset, then release -> first cycle S_RESET with all strobes 0. Next cycle FETCH: ir_write=1, pc_write=1, alu_src_b=10.
- op=0000011 (lw) -> DECODE, MEMADR, MEMREAD (adr_src=1), MEMWB (result_src=01, reg_write=1), FETCH. That is 5 cycles, imm_src=00 throughout.
- op=0110011, funct3=000, funct7_5=1 -> EXECUTER with alu_control=001. Same fields with op=0010011 -> EXECUTEI with alu_control=000. Both then pass through ALUWB with reg_write=1.
- op=1100011, funct3=001 (bne):
  - zero=0 in BRANCH -> pc_write=1, imm_src=10.
  - zero=1 -> pc_write=0.
  - funct3=000 (beq) with zero=1 -> pc_write=1.
- op=1101111 (jal) -> JAL (pc_write=1, alu_src_a=01, imm_src=11), then ALUWB, FETCH. op=0100011 (sw) -> MEMWRITE with mem_write=1, imm_src=01.
- op=1111111 -> illegal_instr=1 in DECODE, next state FETCH. Separately, assert reset during MEMWRITE -> mem_write drops to 0 asynchronously and the state is S_RESET.
